// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state codes, button indices and helpers for the Pong game controller
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int BTN_P1_UP = 0;
  localparam int BTN_P1_DN = 1;
  localparam int BTN_P2_UP = 2;
  localparam int BTN_P2_DN = 3;
  localparam int SCORE_W   = 4;

  // Opposing presses cancel so a paddle never receives {down, up} = 11.
  function automatic logic [1:0] pad_move(input logic up, input logic dn);
    return (up & dn) ? 2'b00 : {dn, up};
  endfunction

endpackage

// File: rtl/pong_btn_sync.sv
// rtl/pong_btn_sync.sv - button synchronizer with frame-rate sampling and press-edge detect
module pong_btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_tick,
  input  logic [W-1:0] btn,
  output logic [W-1:0] sample,
  output logic         press
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;
  logic [W-1:0] btn_s_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      btn_s_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      if (frame_tick) btn_s_q <= sync2_q;
    end
  end

  // sample is the value being latched this tick; press compares it to the previous tick's value.
  assign sample = sync2_q;
  assign press  = frame_tick & (|(sync2_q & ~btn_s_q));

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game FSM, scores and per-frame strobes; optional AI p2 paddle via PONG_AI_EN
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int AI_DEADBAND  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [3:0]         btn,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic [9:0]         ball_y,
  input  logic [9:0]         pad2_y,
  output logic               ball_step,
  output logic               ball_center,
  output logic               serve_dir,
  output logic [1:0]         pad1_mv,
  output logic [1:0]         pad2_mv,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [2:0]         state
);

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               step_q, step_d, center_q, center_d;
  logic [1:0]         mv1_q, mv1_d, mv2_q, mv2_d;

  logic [3:0] sample;
  logic       press;
  logic [1:0] pad1_req;
  logic [1:0] pad2_req;

  pong_btn_sync #(.W(4)) u_btn_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn        (btn),
    .sample     (sample),
    .press      (press)
  );

  assign pad1_req = pad_move(sample[BTN_P1_UP], sample[BTN_P1_DN]);

`ifdef PONG_AI_EN
  logic [10:0] ai_ball;
  logic [10:0] ai_pad;
  logic        unused_ai;
  assign ai_ball   = {1'b0, ball_y};
  assign ai_pad    = {1'b0, pad2_y};
  assign pad2_req  = {ai_ball > ai_pad + 11'(AI_DEADBAND), ai_ball + 11'(AI_DEADBAND) < ai_pad};
  assign unused_ai = ^sample[BTN_P2_DN:BTN_P2_UP];
`else
  logic unused_ai;
  assign pad2_req  = pad_move(sample[BTN_P2_UP], sample[BTN_P2_DN]);
  assign unused_ai = ^{ball_y, pad2_y};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      score1_q <= '0;
      score2_q <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      center_q <= 1'b0;
      mv1_q    <= 2'b00;
      mv2_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      center_q <= center_d;
      mv1_q    <= mv1_d;
      mv2_q    <= mv2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    center_d = 1'b0;
    mv1_d    = 2'b00;
    mv2_d    = 2'b00;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (press) begin
          score1_d = '0;
          score2_d = '0;
          dir_d    = 1'b0;
          center_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          mv1_d = pad1_req;
          mv2_d = pad2_req;
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        // A miss pre-empts the frame strobes, and miss_left takes priority.
        if (miss_left) begin
          if (score2_q < WIN) score2_d = score2_q + 1'b1;
          dir_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_POINT;
        end else if (miss_right) begin
          if (score1_q < WIN) score1_d = score1_q + 1'b1;
          dir_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_POINT;
        end else if (frame_tick) begin
          step_d = 1'b1;
          mv1_d  = pad1_req;
          mv2_d  = pad2_req;
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(POINT_FRAMES - 1)) begin
            cnt_d = '0;
            if (score1_q == WIN || score2_q == WIN) begin
              state_d = ST_OVER;
            end else begin
              center_d = 1'b1;
              state_d  = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ball_step   = step_q;
  assign ball_center = center_q;
  assign serve_dir   = dir_q;
  assign pad1_mv     = mv1_q;
  assign pad2_mv     = mv2_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized scoreboard bench for pong_game_ctrl against a game-rule model
module tb_pong_game_ctrl;

  localparam int WIN   = 2;
  localparam int SERVE = 3;
  localparam int POINT = 4;
  localparam int DB    = 4;
  localparam int NCYC  = 6000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [3:0] btn;
  logic       miss_left, miss_right;
  logic [9:0] ball_y, pad2_y;
  logic       ball_step, ball_center, serve_dir;
  logic [1:0] pad1_mv, pad2_mv;
  logic [3:0] score1, score2;
  logic [2:0] state;

  pong_game_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SERVE),
    .POINT_FRAMES (POINT),
    .AI_DEADBAND  (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .btn         (btn),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .ball_y      (ball_y),
    .pad2_y      (pad2_y),
    .ball_step   (ball_step),
    .ball_center (ball_center),
    .serve_dir   (serve_dir),
    .pad1_mv     (pad1_mv),
    .pad2_mv     (pad2_mv),
    .score1      (score1),
    .score2      (score2),
    .state       (state)
  );

  always #5 clk = ~clk;

  logic [17:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Game model: phase names and frame counts follow the written game rules.
  localparam int IDLE = 0, SRV = 1, PLAY = 2, PNT = 3, OVER = 4;
  int m_phase, m_s1, m_s2, m_dir, m_frames;
  int m_btn_hist[2];
  int m_btn_seen;

  function automatic int move(input int up, input int dn);
    if (up != 0 && dn != 0) return 0;
    return dn * 2 + up;
  endfunction

  task automatic model_step(input bit r, input bit tick, input bit ml, input bit mr,
                            input int b, input int by, input int py, output logic [17:0] e);
    int step, center, p1, p2, seen;
    bit pressed;
    step = 0; center = 0; p1 = 0; p2 = 0;
    if (!r) begin
      m_phase = IDLE; m_s1 = 0; m_s2 = 0; m_dir = 0; m_frames = 0;
      m_btn_hist[0] = 0; m_btn_hist[1] = 0; m_btn_seen = 0;
    end else begin
      seen    = m_btn_hist[1];
      pressed = tick && ((seen & ~m_btn_seen & 15) != 0);
      if (m_phase == IDLE || m_phase == OVER) begin
        if (pressed) begin
          m_s1 = 0; m_s2 = 0; m_dir = 0; center = 1; m_frames = 0; m_phase = SRV;
        end
      end else if (m_phase == SRV) begin
        if (tick) begin
          p1 = move(seen & 1, (seen >> 1) & 1);
`ifdef PONG_AI_EN
          p2 = (by > py + DB) ? 2 : ((by + DB < py) ? 1 : 0);
`else
          p2 = move((seen >> 2) & 1, (seen >> 3) & 1);
`endif
          m_frames++;
          if (m_frames == SERVE) begin m_frames = 0; m_phase = PLAY; end
        end
      end else if (m_phase == PLAY) begin
        if (ml) begin
          m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2; m_dir = 0; m_phase = PNT; m_frames = 0;
        end else if (mr) begin
          m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1; m_dir = 1; m_phase = PNT; m_frames = 0;
        end else if (tick) begin
          step = 1;
          p1 = move(seen & 1, (seen >> 1) & 1);
`ifdef PONG_AI_EN
          p2 = (by > py + DB) ? 2 : ((by + DB < py) ? 1 : 0);
`else
          p2 = move((seen >> 2) & 1, (seen >> 3) & 1);
`endif
        end
      end else if (m_phase == PNT) begin
        if (tick) begin
          m_frames++;
          if (m_frames == POINT) begin
            m_frames = 0;
            if (m_s1 == WIN || m_s2 == WIN) m_phase = OVER;
            else begin center = 1; m_phase = SRV; end
          end
        end
      end
      if (tick) m_btn_seen = seen;
      m_btn_hist[1] = m_btn_hist[0];
      m_btn_hist[0] = b;
    end
    e = {3'(m_phase), 4'(m_s1), 4'(m_s2), 1'(m_dir), 1'(center), 1'(step), 2'(p1), 2'(p2)};
  endtask

  // Monitor: every clock the DUT presents a full registered output set to score.
  initial begin
    logic [17:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      got = {state, score1, score2, serve_dir, ball_center, ball_step, pad1_mv, pad2_mv};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL no_expected t=%0t got=%h want=<none>", $time, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL outputs t=%0t got st=%0d s1=%0d s2=%0d dir=%b ctr=%b step=%b p1=%b p2=%b want st=%0d s1=%0d s2=%0d dir=%b ctr=%b step=%b p1=%b p2=%b",
                   $time, got[17:15], got[14:11], got[10:7], got[6], got[5], got[4], got[3:2], got[1:0],
                   want[17:15], want[14:11], want[10:7], want[6], want[5], want[4], want[3:2], want[1:0]);
        end
      end
    end
  end

  initial begin
    logic [17:0] e;
    int b, by, py;
    b = 0; by = 0; py = 0;
    rst_n = 1'b0; frame_tick = 1'b0; btn = '0; miss_left = 1'b0; miss_right = 1'b0;
    ball_y = '0; pad2_y = '0;
    for (int k = 0; k < NCYC; k++) begin
      rst_n      = (k < 3) ? 1'b0 : ($urandom_range(0, 999) != 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      miss_left  = ($urandom_range(0, 9) == 0);
      miss_right = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) b = $urandom_range(0, 15);
      py = $urandom_range(0, 1023);
      by = ($urandom_range(0, 1) != 0) ? ((py + $urandom_range(0, 14) + 1017) % 1024)
                                       : $urandom_range(0, 1023);
      btn    = 4'(b);
      ball_y = 10'(by);
      pad2_y = 10'(py);
      model_step(rst_n, frame_tick, miss_left, miss_right, b, by, py, e);
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
